// File: rtl/fxp_pkg.sv
// Shared signed fixed-point helpers: width derivation, saturation limits and the
// differentiator FSM encoding. Helpers work on a 64-bit carrier, so W must stay <= 31.
package fxp_pkg;

   localparam int unsigned FXP_WI = 12;
   localparam int unsigned FXP_WF = 12;
   localparam int unsigned XW     = 64;

   function automatic int unsigned fxp_width(input int unsigned wi, input int unsigned wf);
      return wi + wf;
   endfunction

   localparam int unsigned FXP_W = fxp_width(FXP_WI, FXP_WF);
   localparam logic signed [FXP_W-1:0] SAT_MAX = {1'b0, {(FXP_W-1){1'b1}}};
   localparam logic signed [FXP_W-1:0] SAT_MIN = {1'b1, {(FXP_W-1){1'b0}}};

   typedef enum logic [2:0] {StIdle, StMulA, StSub, StMulG, StHold} state_e;

   // Arithmetic shift: truncates toward -inf.
   function automatic logic signed [XW-1:0] fxp_shr(input logic signed [XW-1:0] v,
                                                    input int unsigned wf);
      return v >>> wf;
   endfunction

   function automatic logic fxp_ovf(input logic signed [XW-1:0] v, input int unsigned w);
      logic signed [XW-1:0] lim;
      lim = 64'sd1 <<< (w - 1);
      return (v >= lim) || (v < -lim);
   endfunction

   function automatic logic signed [XW-1:0] fxp_sat(input logic signed [XW-1:0] v,
                                                    input int unsigned w);
      logic signed [XW-1:0] lim;
      lim = 64'sd1 <<< (w - 1);
      if (v >= lim) return lim - 64'sd1;
      if (v < -lim) return -lim;
      return v;
   endfunction

endpackage

// File: rtl/fp_serial_mult.sv
// W-cycle signed shift-add multiplier with Q-format rescale and saturation.
// Bit 0 is folded into the start cycle; bit W-1 (sign weight) is subtracted.
module fp_serial_mult
   import fxp_pkg::*;
#(
   parameter int unsigned WI = FXP_WI,
   parameter int unsigned WF = FXP_WF,
   localparam int unsigned W = fxp_width(WI, WF)
) (
   input  logic                Clk,
   input  logic                RESET,
   input  logic                sync_clr,
   input  logic                start,
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   output logic                done,
   output logic signed [W-1:0] product_sat,
   output logic                ovf
);

   localparam int unsigned CW = $clog2(W);

   logic signed [2*W-1:0] acc_q, mcand_q, a_ext, pp;
   logic [W-1:0]          mplier_q;
   logic [CW-1:0]         cnt_q;
   logic                  busy_q, done_q, last;
   logic signed [XW-1:0]  wide, shifted;

   always_comb begin
      a_ext = {{W{a[W-1]}}, a};
      pp    = mplier_q[0] ? mcand_q : '0;
      last  = (cnt_q == CW'(W - 1));
   end

   always_ff @(posedge Clk or posedge RESET) begin
      if (RESET) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else if (sync_clr) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else if (start) begin
         acc_q    <= b[0] ? a_ext : '0;
         mcand_q  <= a_ext <<< 1;
         mplier_q <= b >> 1;
         cnt_q    <= CW'(1);
         busy_q   <= 1'b1;
         done_q   <= 1'b0;
      end else if (busy_q) begin
         acc_q    <= last ? acc_q - pp : acc_q + pp;
         mcand_q  <= mcand_q <<< 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + CW'(1);
         busy_q   <= ~last;
         done_q   <= last;
      end else begin
         done_q   <= 1'b0;
      end
   end

   always_comb begin
      wide        = {{(XW-2*W){acc_q[2*W-1]}}, acc_q};
      shifted     = fxp_shr(wide, WF);
      product_sat = W'(fxp_sat(shifted, W));
      ovf         = fxp_ovf(shifted, W);
   end

   assign done = done_q;

endmodule

// File: rtl/leaky_differentiator.sv
// Inverse leaky integrator: x[n] = GAIN * (y[n] - ALPHA * y[n-1]), both multiplies
// time-shared on one serial multiplier, valid/ready on each side.
module leaky_differentiator
   import fxp_pkg::*;
#(
   parameter int unsigned      WI    = FXP_WI,
   parameter int unsigned      WF    = FXP_WF,
   parameter logic [WI+WF-1:0] ALPHA = 24'h000E66,
   parameter logic [WI+WF-1:0] GAIN  = 24'h00A000,
   localparam int unsigned     W     = fxp_width(WI, WF)
) (
   input  logic                Clk,
   input  logic                RESET,
   input  logic                sync_clr,
   input  logic signed [W-1:0] in_data,
   input  logic                in_valid,
   output logic                in_ready,
   output logic signed [W-1:0] out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                out_ovf
);

   state_e state_q, state_d;

   logic signed [W-1:0]  y_cur_q, y_prev_q, out_data_q;
   logic                 ovf_acc_q, out_ovf_q;
   logic                 mult_start, mult_done, mult_ovf;
   logic signed [W-1:0]  mult_a, mult_b, mult_p;
   logic [W:0]           diff_wide;
   logic signed [XW-1:0] diff_ext;
   logic signed [W-1:0]  diff_sat;
   logic                 diff_ovf;

   fp_serial_mult #(
      .WI(WI),
      .WF(WF)
   ) u_mult (
      .Clk        (Clk),
      .RESET      (RESET),
      .sync_clr   (sync_clr),
      .start      (mult_start),
      .a          (mult_a),
      .b          (mult_b),
      .done       (mult_done),
      .product_sat(mult_p),
      .ovf        (mult_ovf)
   );

   always_ff @(posedge Clk or posedge RESET) begin
      if (RESET)         state_q <= StIdle;
      else if (sync_clr) state_q <= StIdle;
      else               state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (in_valid)  state_d = StMulA;
         StMulA:  if (mult_done) state_d = StSub;
         StSub:                  state_d = StMulG;
         StMulG:  if (mult_done) state_d = StHold;
         StHold:  if (out_ready) state_d = StIdle;
         default:                state_d = StIdle;
      endcase
   end

   always_comb begin
      in_ready   = (state_q == StIdle);
      out_valid  = (state_q == StHold);
      mult_start = ((state_q == StIdle) && in_valid) || (state_q == StSub);
      mult_a     = (state_q == StSub) ? diff_sat : ALPHA;
      mult_b     = (state_q == StSub) ? GAIN : y_prev_q;
      out_data   = out_data_q;
      out_ovf    = out_ovf_q;
   end

   // Subtraction in W+1 bits, so the only loss is the explicit clamp.
   always_comb begin
      diff_wide = {y_cur_q[W-1], y_cur_q} - {mult_p[W-1], mult_p};
      diff_ext  = {{(XW-W-1){diff_wide[W]}}, diff_wide};
      diff_sat  = W'(fxp_sat(diff_ext, W));
      diff_ovf  = fxp_ovf(diff_ext, W);
   end

   always_ff @(posedge Clk or posedge RESET) begin
      if (RESET) begin
         y_cur_q    <= '0;
         y_prev_q   <= '0;
         ovf_acc_q  <= 1'b0;
         out_data_q <= '0;
         out_ovf_q  <= 1'b0;
      end else if (sync_clr) begin
         y_cur_q    <= '0;
         y_prev_q   <= '0;
         ovf_acc_q  <= 1'b0;
         out_data_q <= '0;
         out_ovf_q  <= 1'b0;
      end else begin
         if ((state_q == StIdle) && in_valid) begin
            y_cur_q   <= in_data;
            ovf_acc_q <= 1'b0;
         end
         if (state_q == StSub) begin
            y_prev_q  <= y_cur_q;
            ovf_acc_q <= ovf_acc_q | mult_ovf | diff_ovf;
         end
         if ((state_q == StMulG) && mult_done) begin
            out_data_q <= mult_p;
            out_ovf_q  <= ovf_acc_q | mult_ovf;
         end
      end
   end

endmodule

// File: tb/tb_leaky_differentiator.sv
// Directed bench for leaky_differentiator: step, truncation, saturation, backpressure,
// clears, back-to-back throughput and a leaky-integrator round trip.
module tb_leaky_differentiator;

   localparam int unsigned W = fxp_pkg::FXP_W;

   logic                Clk = 1'b0;
   logic                RESET, sync_clr, in_valid, out_ready;
   logic signed [W-1:0] in_data;
   logic                in_ready, out_valid, out_ovf;
   logic signed [W-1:0] out_data;

   int n_checks = 0;
   int n_fail   = 0;

   leaky_differentiator dut (
      .Clk      (Clk),
      .RESET    (RESET),
      .sync_clr (sync_clr),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_ovf  (out_ovf)
   );

   always #5 Clk = ~Clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      RESET = 1'b1; sync_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      RESET = 1'b0;
   endtask

   // lat counts clock edges with the accept edge as 1.
   task automatic run_sample(input int y, output int data, output logic ovf, output int lat);
      int guard;
      guard = 0;
      @(negedge Clk);
      while (!in_ready && guard < 200) begin
         @(negedge Clk);
         guard++;
      end
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL accept_wait: in_ready=%0b, expected 1 within 200 cycles", in_ready);
      end
      in_data = W'(y); in_valid = 1'b1;
      @(posedge Clk);
      lat = 1;
      #1 in_valid = 1'b0;
      while (!out_valid && lat < 200) begin
         @(posedge Clk); #1;
         lat++;
      end
      n_checks++;
      if (out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL out_wait: out_valid=%0b, expected 1 within 200 cycles", out_valid);
      end
      data = int'(out_data);
      ovf  = out_ovf;
   endtask

   task automatic test_reset();
      RESET = 1'b1; sync_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
      @(posedge Clk); #1;
      n_checks += 4;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %0b expected 1", in_ready); end
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0b expected 0", out_valid); end
      if (int'(out_data) !== 0) begin n_fail++; $display("FAIL rst_out_data: got %0d expected 0", out_data); end
      if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL rst_out_ovf: got %0b expected 0", out_ovf); end
      @(negedge Clk);
      RESET = 1'b0;
   endtask

   task automatic test_step();
      int d, lat; logic o;
      do_reset();
      run_sample(4096, d, o, lat);
      n_checks += 3;
      if (d !== 40960) begin n_fail++; $display("FAIL step1_data: got %0d expected 40960", d); end
      if (o !== 1'b0) begin n_fail++; $display("FAIL step1_ovf: got %0b expected 0", o); end
      if (lat !== 50) begin n_fail++; $display("FAIL step1_latency: got %0d expected 50", lat); end
      run_sample(4096, d, o, lat);
      n_checks += 2;
      if (d !== 4100) begin n_fail++; $display("FAIL step2_data: got %0d expected 4100", d); end
      if (o !== 1'b0) begin n_fail++; $display("FAIL step2_ovf: got %0b expected 0", o); end
   endtask

   task automatic test_lsb();
      int d, lat; logic o;
      do_reset();
      run_sample(1, d, o, lat);
      n_checks++;
      if (d !== 10) begin n_fail++; $display("FAIL lsb1_data: got %0d expected 10", d); end
      run_sample(1, d, o, lat);
      n_checks++;
      if (d !== 10) begin n_fail++; $display("FAIL lsb2_data: got %0d expected 10", d); end
      do_reset();
      run_sample(-1, d, o, lat);
      n_checks++;
      if (d !== -10) begin n_fail++; $display("FAIL lsb_neg_data: got %0d expected -10", d); end
   endtask

   task automatic test_saturation();
      int d, lat; logic o;
      do_reset();
      run_sample(int'(fxp_pkg::SAT_MAX), d, o, lat);
      n_checks += 2;
      if (d !== 8388607) begin n_fail++; $display("FAIL satp_data: got %0d expected 8388607", d); end
      if (o !== 1'b1) begin n_fail++; $display("FAIL satp_ovf: got %0b expected 1", o); end
      do_reset();
      run_sample(int'(fxp_pkg::SAT_MIN), d, o, lat);
      n_checks += 2;
      if (d !== -8388608) begin n_fail++; $display("FAIL satn_data: got %0d expected -8388608", d); end
      if (o !== 1'b1) begin n_fail++; $display("FAIL satn_ovf: got %0b expected 1", o); end
      // alpha*(-2^23) = -7548928 exactly, so this sample differences to zero.
      run_sample(-7548928, d, o, lat);
      n_checks += 2;
      if (d !== 0) begin n_fail++; $display("FAIL sat_next_data: got %0d expected 0", d); end
      if (o !== 1'b0) begin n_fail++; $display("FAIL sat_next_ovf: got %0b expected 0", o); end
   endtask

   task automatic test_backpressure();
      int d, lat; logic o;
      do_reset();
      out_ready = 1'b0;
      run_sample(1, d, o, lat);
      for (int i = 0; i < 20; i++) begin
         @(negedge Clk);
         in_valid = (i == 5);
         in_data  = W'(12345);
         @(posedge Clk); #1;
         n_checks++;
         if (out_valid !== 1'b1 || int'(out_data) !== 10 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_stall cycle %0d: valid=%0b data=%0d in_ready=%0b, expected 1/10/0",
                     i, out_valid, out_data, in_ready);
         end
      end
      @(negedge Clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge Clk); #1;
      n_checks += 2;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %0b expected 0", out_valid); end
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %0b expected 1", in_ready); end
      @(posedge Clk); #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_idle_hold: got %0b expected 1", in_ready); end
      // y_prev must still be 1, not the 12345 offered during the stall.
      run_sample(1, d, o, lat);
      n_checks++;
      if (d !== 10) begin n_fail++; $display("FAIL bp_next_data: got %0d expected 10", d); end
   endtask

   task automatic test_mid_reset();
      int d, lat; logic o;
      do_reset();
      run_sample(4096, d, o, lat);
      @(negedge Clk);
      in_data = W'(8192); in_valid = 1'b1;
      @(posedge Clk);
      #1 in_valid = 1'b0;
      repeat (W + 5) @(posedge Clk);
      #3 RESET = 1'b1;
      #1;
      n_checks += 3;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_in_ready: got %0b expected 1", in_ready); end
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %0b expected 0", out_valid); end
      if (int'(out_data) !== 0) begin n_fail++; $display("FAIL mid_rst_data: got %0d expected 0", out_data); end
      @(negedge Clk);
      RESET = 1'b0;
      run_sample(4096, d, o, lat);
      n_checks += 2;
      if (d !== 40960) begin n_fail++; $display("FAIL mid_rst_next_data: got %0d expected 40960", d); end
      if (o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_next_ovf: got %0b expected 0", o); end
   endtask

   task automatic test_sync_clr();
      int d, lat; logic o;
      do_reset();
      run_sample(4096, d, o, lat);
      @(negedge Clk);
      in_data = W'(4096); in_valid = 1'b1;
      @(posedge Clk);
      #1 in_valid = 1'b0;
      repeat (5) @(posedge Clk);
      @(negedge Clk);
      sync_clr = 1'b1;
      @(posedge Clk); #1;
      n_checks += 3;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL sclr_in_ready: got %0b expected 1", in_ready); end
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sclr_valid: got %0b expected 0", out_valid); end
      if (int'(out_data) !== 0) begin n_fail++; $display("FAIL sclr_data: got %0d expected 0", out_data); end
      @(negedge Clk);
      sync_clr = 1'b0;
      run_sample(4096, d, o, lat);
      n_checks++;
      if (d !== 40960) begin n_fail++; $display("FAIL sclr_next_data: got %0d expected 40960", d); end
   endtask

   task automatic test_back_to_back();
      int rise1, rise2, d1, d2;
      logic prev;
      do_reset();
      @(negedge Clk);
      in_data = W'(4096); in_valid = 1'b1;
      rise1 = 0; rise2 = 0; d1 = 0; d2 = 0; prev = 1'b0;
      for (int e = 1; e <= 300 && rise2 == 0; e++) begin
         @(posedge Clk); #1;
         if (out_valid && !prev) begin
            if (rise1 == 0) begin rise1 = e; d1 = int'(out_data); end
            else begin rise2 = e; d2 = int'(out_data); end
         end
         prev = out_valid;
      end
      @(negedge Clk);
      in_valid = 1'b0;
      n_checks += 4;
      if (rise1 !== 50) begin n_fail++; $display("FAIL b2b_first_latency: got %0d expected 50", rise1); end
      if (rise2 - rise1 !== 51) begin n_fail++; $display("FAIL b2b_period: got %0d expected 51", rise2 - rise1); end
      if (d1 !== 40960) begin n_fail++; $display("FAIL b2b_data1: got %0d expected 40960", d1); end
      if (d2 !== 4100) begin n_fail++; $display("FAIL b2b_data2: got %0d expected 4100", d2); end
   endtask

   // Integer leaky integrator with the same Q12 leak (3686) and a 1/10 input gain
   // rounded to nearest; ties are nudged off so the gain step stays within 4 LSB.
   task automatic test_round_trip();
      longint yprev, p1;
      int x, q, r, y, d, lat, err;
      logic o;
      do_reset();
      yprev = 0;
      for (int i = 0; i < 12; i++) begin
         x = int'($urandom_range(819200)) - 409600;
         if (x % 10 == 5 || x % 10 == -5) x = x + 1;
         q = x / 10;
         r = x - 10 * q;
         if (r > 5) q = q + 1;
         if (r < -5) q = q - 1;
         p1 = (64'sd3686 * yprev) >>> 12;
         y = int'(p1) + q;
         yprev = longint'(y);
         run_sample(y, d, o, lat);
         err = d - x;
         n_checks += 2;
         if (err > 4 || err < -4) begin
            n_fail++;
            $display("FAIL rt_data[%0d]: got %0d expected %0d +/-4", i, d, x);
         end
         if (o !== 1'b0) begin n_fail++; $display("FAIL rt_ovf[%0d]: got %0b expected 0", i, o); end
      end
   endtask

   initial begin
      test_reset();
      test_step();
      test_lsb();
      test_saturation();
      test_backpressure();
      test_mid_reset();
      test_sync_clr();
      test_back_to_back();
      test_round_trip();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
